// File: rtl/sys_defs.sv
// Shared definitions for the reservation-station issue path: FU class
// encoding, multiplier/CDB timing constants and the multiply tracker entry.
package sys_defs;

  localparam int FU_LEN    = 2;
  localparam int MUL_LAT   = 4;
  localparam int CDB_WIDTH = 2;
  localparam int BRAT_SIZE = 4;

  typedef enum logic [FU_LEN-1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_BR  = 2'd2,
    FU_MEM = 2'd3
  } fu_t;

  // One in-flight multiply: occupied flag plus the branch mask it depends on
  typedef struct packed {
    logic                 valid;
    logic [BRAT_SIZE-1:0] mask;
  } MUL_TRACK_ENTRY;

  // ALU and BR share the one-cycle writeback path to the CDB
  function automatic logic fu_is_fast(input logic [FU_LEN-1:0] fu);
    return (fu == FU_ALU) || (fu == FU_BR);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request bit at or after
// ptr, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N   = 16,
  parameter int LEN = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [LEN-1:0] ptr,
  output logic           vld,
  output logic [LEN-1:0] idx
);

  logic [LEN-1:0] j;

  // Walk offsets from farthest to nearest so the nearest hit is written last
  always_comb begin
    vld = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = N-1; k >= 0; k--) begin
      j = LEN'((int'(ptr) + k) % N);
      if (req[j]) begin
        vld = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/rs_issue_sched.sv
// Dual-issue scheduler for the reservation station. Picks up to two ready
// entries in rotating order, applies per-class FU limits, and tracks issued
// multiplies so that fast ops never oversubscribe the CDB.
module rs_issue_sched
  import sys_defs::*;
#(
  parameter int RS_SIZE   = 16,
  parameter int BRAT_SIZE = sys_defs::BRAT_SIZE,
  parameter int MUL_LAT   = sys_defs::MUL_LAT,
  parameter int CDB_WIDTH = sys_defs::CDB_WIDTH,
  localparam int RS_LEN   = $clog2(RS_SIZE)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [RS_SIZE-1:0]                 rs_valid_in,
  input  logic [RS_SIZE-1:0]                 rs_rdy_in,
  input  logic [RS_SIZE-1:0][FU_LEN-1:0]     rs_fu_in,
  input  logic [RS_SIZE-1:0][BRAT_SIZE-1:0]  rs_mask_in,
  input  logic [BRAT_SIZE-1:0]               brat_mis,
  input  logic                               stall_in,
  input  logic                               mem_rdy_in,
  output logic                               grant1_valid,
  output logic                               grant2_valid,
  output logic [RS_LEN-1:0]                  grant1_idx,
  output logic [RS_LEN-1:0]                  grant2_idx,
  output logic                               mul_in_use1,
  output logic                               mul_in_use2,
  output logic                               mul_wb_next,
  output logic [RS_LEN-1:0]                  rr_ptr_out
);

  // Tracker depth: stage k holds a multiply issued k+1 cycles ago; the last
  // stage writes back on the following cycle.
  localparam int TRK = MUL_LAT - 1;

  logic [RS_LEN-1:0]          rr_ptr;
  MUL_TRACK_ENTRY [TRK-1:0]   mul_pipe;
  MUL_TRACK_ENTRY             shift_in;
  logic [TRK-1:0]             hit;

  logic [RS_SIZE-1:0]         cand, is_mul, is_mem, is_fast;
  logic [RS_SIZE-1:0]         req1, req2, win1_oh;
  logic                       run;
  int                         fast_cap;
  logic [FU_LEN-1:0]          fu1;
  logic                       w1_mul, w1_mem, w1_fast;
  logic                       v1, v2;
  logic [RS_LEN-1:0]          idx1, idx2, mul_idx;

  // Squash hits per tracker stage against the current mispredict
  always_comb begin
    hit = '0;
    for (int k = 0; k < TRK; k++)
      hit[k] = |(mul_pipe[k].mask & brat_mis);
  end

  // A surviving multiply in the last stage claims a CDB port next cycle
  assign mul_wb_next = mul_pipe[TRK-1].valid & ~hit[TRK-1];

  // Per-entry candidacy and FU class decode; reset and stall block issue
  always_comb begin
    run      = reset & ~stall_in;
    fast_cap = CDB_WIDTH - int'(mul_wb_next);
    cand     = '0;
    is_mul   = '0;
    is_mem   = '0;
    is_fast  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      cand[i]    = run & rs_valid_in[i] & rs_rdy_in[i] & ~|(rs_mask_in[i] & brat_mis);
      is_mul[i]  = (rs_fu_in[i] == FU_MUL);
      is_mem[i]  = (rs_fu_in[i] == FU_MEM);
      is_fast[i] = fu_is_fast(rs_fu_in[i]);
    end
  end

  // Slot 1 may take any class whose limit still has room with zero grants
  always_comb begin
    req1 = cand & (is_mul
                 | (is_mem  & {RS_SIZE{mem_rdy_in}})
                 | (is_fast & {RS_SIZE{fast_cap >= 1}}));
  end

  rr_pick #(.N(RS_SIZE), .LEN(RS_LEN)) u_pick1 (
    .req (req1),
    .ptr (rr_ptr),
    .vld (v1),
    .idx (idx1)
  );

  // Slot 2 sees slot 1's request set minus its winner and any class that
  // slot 1 has used up. Because this set is a subset of req1, searching from
  // rr_ptr again yields the next eligible entry after slot 1's winner.
  always_comb begin
    fu1     = rs_fu_in[idx1];
    w1_mul  = v1 & (fu1 == FU_MUL);
    w1_mem  = v1 & (fu1 == FU_MEM);
    w1_fast = v1 & fu_is_fast(fu1);
    win1_oh = '0;
    for (int i = 0; i < RS_SIZE; i++)
      win1_oh[i] = v1 & (idx1 == RS_LEN'(i));
    req2 = req1 & ~win1_oh
                & ~(is_mul  & {RS_SIZE{w1_mul}})
                & ~(is_mem  & {RS_SIZE{w1_mem}})
                & ~(is_fast & {RS_SIZE{(fast_cap - int'(w1_fast)) < 1}});
  end

  rr_pick #(.N(RS_SIZE), .LEN(RS_LEN)) u_pick2 (
    .req (req2),
    .ptr (rr_ptr),
    .vld (v2),
    .idx (idx2)
  );

  // Grant outputs and the multiply being shifted into the tracker
  always_comb begin
    grant1_valid   = v1;
    grant1_idx     = idx1;
    grant2_valid   = v2;
    grant2_idx     = idx2;
    mul_in_use1    = w1_mul;
    mul_in_use2    = v2 & (rs_fu_in[idx2] == FU_MUL);
    mul_idx        = w1_mul ? idx1 : idx2;
    shift_in.mask  = rs_mask_in[mul_idx];
    shift_in.valid = (mul_in_use1 | mul_in_use2) & ~|(rs_mask_in[mul_idx] & brat_mis);
  end

  assign rr_ptr_out = rr_ptr;

  // Priority pointer moves just past slot 1's winner; holds otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (grant1_valid)
      rr_ptr <= (grant1_idx == RS_LEN'(RS_SIZE-1)) ? '0 : grant1_idx + 1'b1;
  end

  // Multiply tracker shifts every cycle, stalled or not, dropping squashed stages
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mul_pipe <= '0;
    end else begin
      mul_pipe[0] <= shift_in;
      for (int k = 1; k < TRK; k++) begin
        mul_pipe[k].valid <= mul_pipe[k-1].valid & ~hit[k-1];
        mul_pipe[k].mask  <= mul_pipe[k-1].mask;
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a list-based
// model of grants, pointer and in-flight multiplies.
module tb_rs_issue_sched;

  localparam int RS  = 16;
  localparam int ML  = 4;
  localparam int CDB = 2;

  logic             clock, reset;
  logic [RS-1:0]    rs_valid_in, rs_rdy_in;
  logic [RS-1:0][1:0] rs_fu_in;
  logic [RS-1:0][3:0] rs_mask_in;
  logic [3:0]       brat_mis;
  logic             stall_in, mem_rdy_in;
  logic             grant1_valid, grant2_valid;
  logic [3:0]       grant1_idx, grant2_idx;
  logic             mul_in_use1, mul_in_use2, mul_wb_next;
  logic [3:0]       rr_ptr_out;

  rs_issue_sched dut (
    .clock        (clock),
    .reset        (reset),
    .rs_valid_in  (rs_valid_in),
    .rs_rdy_in    (rs_rdy_in),
    .rs_fu_in     (rs_fu_in),
    .rs_mask_in   (rs_mask_in),
    .brat_mis     (brat_mis),
    .stall_in     (stall_in),
    .mem_rdy_in   (mem_rdy_in),
    .grant1_valid (grant1_valid),
    .grant2_valid (grant2_valid),
    .grant1_idx   (grant1_idx),
    .grant2_idx   (grant2_idx),
    .mul_in_use1  (mul_in_use1),
    .mul_in_use2  (mul_in_use2),
    .mul_wb_next  (mul_wb_next),
    .rr_ptr_out   (rr_ptr_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec, n_err;

  // Model state: pointer and a list of in-flight multiplies (cycles since issue, mask)
  int         m_ptr;
  int         q_age[$];
  logic [3:0] q_mask[$];
  // Expected outputs for the current cycle
  bit e_g1v, e_g2v, e_m1, e_m2, e_wb;
  int e_g1, e_g2;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Greedy walk in priority order, counting grants per class
  task automatic model_eval();
    int n, muls, mems, fasts, i, f;
    bit ok;
    if (!reset) begin
      m_ptr = 0;
      q_age.delete();
      q_mask.delete();
    end
    e_wb = 0;
    foreach (q_age[k])
      if (q_age[k] == ML-1 && (q_mask[k] & brat_mis) == 0) e_wb = 1;
    e_g1v = 0; e_g2v = 0; e_m1 = 0; e_m2 = 0; e_g1 = 0; e_g2 = 0;
    n = 0; muls = 0; mems = 0; fasts = 0;
    if (reset && !stall_in) begin
      for (int off = 0; off < RS; off++) begin
        i = (m_ptr + off) % RS;
        if (n < 2 && rs_valid_in[i] && rs_rdy_in[i] && (rs_mask_in[i] & brat_mis) == 0) begin
          f  = int'(rs_fu_in[i]);
          ok = 0;
          if (f == 1) begin
            if (muls < 1) begin ok = 1; muls++; end
          end else if (f == 3) begin
            if (mems < 1 && mem_rdy_in) begin ok = 1; mems++; end
          end else begin
            if (fasts < CDB - int'(e_wb)) begin ok = 1; fasts++; end
          end
          if (ok) begin
            if (n == 0) begin e_g1v = 1; e_g1 = i; e_m1 = (f == 1); end
            else        begin e_g2v = 1; e_g2 = i; e_m2 = (f == 1); end
            n++;
          end
        end
      end
    end
  endtask

  // Clock-edge update of the model
  task automatic model_commit();
    int         na[$];
    logic [3:0] nm[$];
    foreach (q_age[k])
      if ((q_mask[k] & brat_mis) == 0 && q_age[k] + 1 < ML) begin
        na.push_back(q_age[k] + 1);
        nm.push_back(q_mask[k]);
      end
    if (e_m1) begin na.push_back(1); nm.push_back(rs_mask_in[e_g1]); end
    if (e_m2) begin na.push_back(1); nm.push_back(rs_mask_in[e_g2]); end
    q_age  = na;
    q_mask = nm;
    if (e_g1v) m_ptr = (e_g1 + 1) % RS;
  endtask

  // Settle combinational outputs, then compare everything against the model
  task automatic settle();
    #1;
    model_eval();
    check("grant1_valid", grant1_valid, e_g1v);
    if (e_g1v) check("grant1_idx", grant1_idx, e_g1);
    check("grant2_valid", grant2_valid, e_g2v);
    if (e_g2v) check("grant2_idx", grant2_idx, e_g2);
    check("mul_in_use1", mul_in_use1, e_m1);
    check("mul_in_use2", mul_in_use2, e_m2);
    check("mul_wb_next", mul_wb_next, e_wb);
    check("rr_ptr_out", rr_ptr_out, m_ptr);
  endtask

  // Take the edge, then act as the RS: free granted and flushed entries
  task automatic advance();
    @(posedge clock);
    if (reset) model_commit();
    @(negedge clock);
    if (reset) begin
      if (e_g1v) rs_valid_in[e_g1] = 1'b0;
      if (e_g2v) rs_valid_in[e_g2] = 1'b0;
      for (int i = 0; i < RS; i++)
        if ((rs_mask_in[i] & brat_mis) != 0) rs_valid_in[i] = 1'b0;
    end
  endtask

  task automatic clear_all();
    rs_valid_in = '0; rs_rdy_in = '0; rs_fu_in = '0; rs_mask_in = '0;
  endtask

  task automatic set_entry(input int i, input logic [1:0] fu, input logic [3:0] mk);
    rs_valid_in[i] = 1'b1; rs_rdy_in[i] = 1'b1; rs_fu_in[i] = fu; rs_mask_in[i] = mk;
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_ptr = 0;
    reset = 1'b0; brat_mis = '0; stall_in = 1'b0; mem_rdy_in = 1'b1;
    clear_all();
    set_entry(3, 2'd0, 4'b0);
    @(negedge clock);
    // Reset: ready entry present but nothing granted
    settle();
    check("lit_reset_g1v", grant1_valid, 0);
    check("lit_reset_ptr", rr_ptr_out, 0);
    check("lit_reset_wb",  mul_wb_next, 0);
    advance();

    // Oldest-first pair
    reset = 1'b1; clear_all();
    set_entry(3, 2'd0, 4'b0); set_entry(5, 2'd0, 4'b0); set_entry(9, 2'd0, 4'b0);
    settle();
    check("lit_pair_g1", grant1_idx, 3);
    check("lit_pair_g2", grant2_idx, 5);
    check("lit_pair_g2v", grant2_valid, 1);
    advance();
    settle();
    check("lit_pair_ptr", rr_ptr_out, 4);
    check("lit_pair_next_g1", grant1_idx, 9);
    check("lit_pair_next_g2v", grant2_valid, 0);
    advance();

    // Pointer wrap: move pointer to 15, then 15 then 0 win
    set_entry(14, 2'd2, 4'b0);
    settle();
    check("lit_wrap_pre_g1", grant1_idx, 14);
    advance();
    set_entry(0, 2'd0, 4'b0); set_entry(15, 2'd0, 4'b0);
    settle();
    check("lit_wrap_ptr", rr_ptr_out, 15);
    check("lit_wrap_g1", grant1_idx, 15);
    check("lit_wrap_g2", grant2_idx, 0);
    advance();
    settle();
    check("lit_wrap_ptr0", rr_ptr_out, 0);
    check("lit_empty_g1v", grant1_valid, 0);
    advance();

    // MUL limit
    set_entry(2, 2'd1, 4'b0); set_entry(4, 2'd1, 4'b0);
    settle();
    check("lit_mul_g1", grant1_idx, 2);
    check("lit_mul_m1", mul_in_use1, 1);
    check("lit_mul_g2v", grant2_valid, 0);
    advance();
    settle();
    check("lit_mul_next_g1", grant1_idx, 4);
    check("lit_mul_next_m1", mul_in_use1, 1);
    advance();
    repeat (4) begin settle(); advance(); end

    // CDB conflict: MUL at t, three ALUs at t+3
    set_entry(6, 2'd1, 4'b0);
    settle();
    check("lit_cdb_mul", grant1_idx, 6);
    advance();
    settle();
    check("lit_cdb_wb_t1", mul_wb_next, 0);
    advance();
    settle(); advance();
    set_entry(8, 2'd0, 4'b0); set_entry(9, 2'd0, 4'b0); set_entry(10, 2'd0, 4'b0);
    settle();
    check("lit_cdb_wb", mul_wb_next, 1);
    check("lit_cdb_g1", grant1_idx, 8);
    check("lit_cdb_g2v", grant2_valid, 0);
    advance();
    settle();
    check("lit_cdb_after_wb", mul_wb_next, 0);
    check("lit_cdb_after_g2", grant2_idx, 10);
    advance();

    // Mispredict squash
    set_entry(12, 2'd1, 4'b0010);
    settle();
    check("lit_sq_mul", grant1_idx, 12);
    advance();
    brat_mis = 4'b0010;
    set_entry(13, 2'd0, 4'b0010); set_entry(14, 2'd0, 4'b0000);
    settle();
    check("lit_sq_g1", grant1_idx, 14);
    check("lit_sq_g2v", grant2_valid, 0);
    advance();
    brat_mis = '0;
    settle(); advance();
    settle();
    check("lit_sq_wb", mul_wb_next, 0);
    advance();

    // Reset with stall and a multiply in flight
    set_entry(0, 2'd1, 4'b0);
    settle();
    check("lit_rst_mul", mul_in_use1, 1);
    advance();
    stall_in = 1'b1;
    set_entry(1, 2'd0, 4'b0);
    settle();
    check("lit_stall_g1v", grant1_valid, 0);
    reset = 1'b0;
    settle();
    check("lit_rst_g1v", grant1_valid, 0);
    check("lit_rst_m1", mul_in_use1, 0);
    check("lit_rst_wb", mul_wb_next, 0);
    check("lit_rst_ptr", rr_ptr_out, 0);
    advance();
    reset = 1'b1; stall_in = 1'b0; clear_all();
    repeat (5) begin
      settle();
      check("lit_rst_nophantom", mul_wb_next, 0);
      advance();
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < RS; i++) begin
        if (!rs_valid_in[i] && $urandom_range(99) < 30) begin
          rs_valid_in[i] = 1'b1;
          rs_rdy_in[i]   = 1'b0;
          rs_fu_in[i]    = 2'($urandom_range(3));
          rs_mask_in[i]  = ($urandom_range(99) < 30) ? (4'b0001 << $urandom_range(3)) : 4'b0;
        end else if (rs_valid_in[i] && !rs_rdy_in[i] && $urandom_range(99) < 40) begin
          rs_rdy_in[i] = 1'b1;
        end
      end
      brat_mis   = ($urandom_range(99) < 6) ? (4'b0001 << $urandom_range(3)) : 4'b0;
      stall_in   = ($urandom_range(99) < 10);
      mem_rdy_in = ($urandom_range(99) < 70);
      reset      = !($urandom_range(199) == 0);
      settle();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
